// File: rtl/periph_bus_responder.sv
// Memory-mapped peripheral responder: reloadable timer with irq, LED and digit registers.
// Optional free-running SYSTICK counter at offset 0x14 is built when PERIPH_SYSTICK_EN is defined.
module periph_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DIG_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             hit,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [DIG_W-1:0] digits
);

  typedef enum logic [2:0] {
    SEL_TH      = 3'd0,
    SEL_TL      = 3'd1,
    SEL_TCON    = 3'd2,
    SEL_LED     = 3'd3,
    SEL_DIG     = 3'd4,
    SEL_SYSTICK = 3'd5,
    SEL_RSV6    = 3'd6,
    SEL_RSV7    = 3'd7
  } reg_sel_e;

  logic [31:0]      r_th;
  logic [31:0]      r_tl;
  logic [2:0]       r_tcon;
  logic [LED_W-1:0] r_led;
  logic [DIG_W-1:0] r_dig;
  logic [31:0]      w_systick;

  logic     w_hit;
  logic     w_wr;
  reg_sel_e w_sel;
  logic     w_unused_addr;

  assign w_hit         = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_wr          = wr_en & w_hit;
  assign w_sel         = reg_sel_e'(addr[4:2]);
  assign w_unused_addr = ^addr[1:0];

  assign hit    = w_hit;
  assign irq    = r_tcon[2];
  assign leds   = r_led;
  assign digits = r_dig;

  // Bus write is placed after the timer update so its NBA overrides a same-edge count/reload/status set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
      r_led  <= '0;
      r_dig  <= '0;
    end else begin
      if (r_tcon[0]) begin
        if (r_tl == '1) begin
          r_tl <= r_th;
          if (r_tcon[1]) r_tcon[2] <= 1'b1;
        end else begin
          r_tl <= r_tl + 32'd1;
        end
      end
      if (w_wr) begin
        case (w_sel)
          SEL_TH:   r_th   <= wdata;
          SEL_TL:   r_tl   <= wdata;
          SEL_TCON: r_tcon <= wdata[2:0];
          SEL_LED:  r_led  <= wdata[LED_W-1:0];
          SEL_DIG:  r_dig  <= wdata[DIG_W-1:0];
          default:  ;
        endcase
      end
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] r_systick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_systick <= '0;
    else       r_systick <= r_systick + 32'd1;
  end

  assign w_systick = r_systick;
`else
  assign w_systick = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en && w_hit) begin
      case (w_sel)
        SEL_TH:      rdata = r_th;
        SEL_TL:      rdata = r_tl;
        SEL_TCON:    rdata = {29'd0, r_tcon};
        SEL_LED:     rdata = 32'(r_led);
        SEL_DIG:     rdata = 32'(r_dig);
        SEL_SYSTICK: rdata = w_systick;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_responder.sv
// Scoreboard bench for periph_bus_responder: read expectations are queued at drive time
// and compared on the following falling edge while the read strobe is held.
module tb_periph_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        hit, irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  localparam logic [31:0] B = 32'h4000_0000;

  periph_bus_responder #(.BASE_ADDR(B), .LED_W(8), .DIG_W(12)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .hit(hit), .irq(irq), .leds(leds), .digits(digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        hit;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Reference free-running tick count for the SYSTICK register.
  always @(posedge clk or posedge reset) begin
    if (reset) m_tick <= '0;
    else       m_tick <= m_tick + 32'd1;
  end

  always @(negedge clk) begin
    if (rd_en) begin
      if (sb.size() == 0) begin
        check("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, rdata, e.rdata);
        check({e.tag, "_hit"}, {31'd0, hit}, {31'd0, e.hit});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_hit);
    exp_t e;
    e.tag = tag; e.rdata = exp; e.hit = exp_hit;
    sb.push_back(e);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_digits", {20'd0, digits}, 32'd0);

    // LED / digit registers
    wr(B + 32'h0C, 32'h0000_01A5);
    check("leds_a5", {24'd0, leds}, 32'h0000_00A5);
    wr(B + 32'h10, 32'hFFFF_F123);
    check("digits_123", {20'd0, digits}, 32'h0000_0123);
    rd("rd_dig", B + 32'h10, 32'h0000_0123, 1'b1);
    rd("rd_led", B + 32'h0C, 32'h0000_00A5, 1'b1);

    // Timer reload and irq
    wr(B + 32'h00, 32'hFFFF_FFFC);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'h0000_0003);
    check("irq_s0", {31'd0, irq}, 32'd0);
    rd("tl_s0", B + 32'h04, 32'hFFFF_FFFE, 1'b1);
    check("irq_s1", {31'd0, irq}, 32'd0);
    rd("tl_s1", B + 32'h04, 32'hFFFF_FFFF, 1'b1);
    check("irq_s2", {31'd0, irq}, 32'd1);
    rd("tl_reload", B + 32'h04, 32'hFFFF_FFFC, 1'b1);
    check("irq_sticky", {31'd0, irq}, 32'd1);
    wr(B + 32'h08, 32'h0000_0003);
    check("irq_clear", {31'd0, irq}, 32'd0);
    rd("tl_s4", B + 32'h04, 32'hFFFF_FFFE, 1'b1);

    // TL write on the overflow edge wins over the reload; status still sets
    wr(B + 32'h04, 32'h0000_0010);
    check("irq_tl_coll", {31'd0, irq}, 32'd1);
    rd("tl_coll", B + 32'h04, 32'h0000_0010, 1'b1);
    wr(B + 32'h08, 32'h0000_0003);
    check("irq_clear2", {31'd0, irq}, 32'd0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    tick();
    // TCON write on the overflow edge wins entirely
    wr(B + 32'h08, 32'h0000_0001);
    check("irq_tcon_coll", {31'd0, irq}, 32'd0);
    rd("tcon_coll", B + 32'h08, 32'h0000_0001, 1'b1);
    rd("tl_after_coll", B + 32'h04, 32'hFFFF_FFFD, 1'b1);
    wr(B + 32'h08, 32'h0000_0000);
    rd("tl_stop", B + 32'h04, 32'hFFFF_FFFF, 1'b1);
    rd("tl_hold", B + 32'h04, 32'hFFFF_FFFF, 1'b1);

    // TH write on the overflow edge: reload uses old TH
    wr(B + 32'h08, 32'h0000_0001);
    wr(B + 32'h00, 32'h0000_0055);
    rd("tl_old_th", B + 32'h04, 32'hFFFF_FFFC, 1'b1);
    wr(B + 32'h08, 32'h0000_0000);
    rd("th_new", B + 32'h00, 32'h0000_0055, 1'b1);

    // TCON stores only bits [2:0]; bit 2 write sets status
    wr(B + 32'h08, 32'hFFFF_FFF4);
    check("irq_sw_set", {31'd0, irq}, 32'd1);
    rd("tcon_mask", B + 32'h08, 32'h0000_0004, 1'b1);
    wr(B + 32'h08, 32'h0000_0000);
    check("irq_sw_clr", {31'd0, irq}, 32'd0);

    // Decode
    rd("rsv18", B + 32'h18, 32'h0, 1'b1);
    rd("out_20", B + 32'h20, 32'h0, 1'b0);
    rd("below", 32'h3FFF_FFFC, 32'h0, 1'b0);
    wr(B + 32'h20, 32'h0000_DEAD);
    wr(B + 32'h2C, 32'h0000_0000);
    rd("th_no_alias", B + 32'h00, 32'h0000_0055, 1'b1);
    check("leds_no_alias", {24'd0, leds}, 32'h0000_00A5);
    addr = B + 32'h0C; rd_en = 1'b0; #1;
    check("rd_en_low", rdata, 32'h0);

    // Read and write in the same cycle: read sees the pre-write value
    addr = B + 32'h0C; wdata = 32'h0000_003C; wr_en = 1'b1;
    rd("rw_same", B + 32'h0C, 32'h0000_00A5, 1'b1);
    wr_en = 1'b0;
    check("leds_3c", {24'd0, leds}, 32'h0000_003C);
    rd("byte_ofs", B + 32'h0F, 32'h0000_003C, 1'b1);

    // SYSTICK
`ifdef PERIPH_SYSTICK_EN
    rd("systick_a", B + 32'h14, m_tick, 1'b1);
    repeat (4) tick();
    rd("systick_b", B + 32'h14, m_tick, 1'b1);
    wr(B + 32'h14, 32'h0000_0000);
    rd("systick_wr", B + 32'h14, m_tick, 1'b1);
`else
    rd("systick_off", B + 32'h14, 32'h0, 1'b1);
    wr(B + 32'h14, 32'h1234_5678);
    rd("systick_off2", B + 32'h14, 32'h0, 1'b1);
`endif

    // Reset asserted mid-count with irq pending
    wr(B + 32'h08, 32'hFFFF_FFF7);
    check("irq_pre_rst", {31'd0, irq}, 32'd1);
    reset = 1'b1; #1;
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_leds", {24'd0, leds}, 32'd0);
    check("midrst_digits", {20'd0, digits}, 32'd0);
    tick();
    reset = 1'b0;
    rd("midrst_th", B + 32'h00, 32'h0, 1'b1);
    rd("midrst_tl", B + 32'h04, 32'h0, 1'b1);
    rd("midrst_tcon", B + 32'h08, 32'h0, 1'b1);
    rd("midrst_tl_idle", B + 32'h04, 32'h0, 1'b1);

    tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
